// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder back end.
// Field widths, rounding modes, flag positions and FSM states.
package fp_pkg;

    function automatic int exp_size(input int size);
        return (size == 32) ? 8 : 11;
    endfunction

    function automatic int mant_size(input int size);
        return (size == 32) ? 23 : 52;
    endfunction

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        PACK
    } state_t;

    // Encodings above RMM have no meaning here and fall back to RNE.
    function automatic logic [2:0] rm_norm(input logic [2:0] rm);
        return (rm > RM_RMM) ? RM_RNE : rm;
    endfunction

endpackage

// File: rtl/fp_round_incr.sv
// IEEE-754 round-increment decision from lsb/guard/round/sticky.
// Shared by the adder back end and the future multiplier.
module fp_round_incr
    import fp_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       r,
    input  logic       s,
    output logic       incr,
    output logic       inexact
);

    // Pick the increment for the active rounding mode.
    always_comb begin
        inexact = g | r | s;
        incr    = 1'b0;
        unique case (1'b1)
            (rm == RM_RTZ): incr = 1'b0;
            (rm == RM_RDN): incr = inexact & sign;
            (rm == RM_RUP): incr = inexact & ~sign;
            (rm == RM_RMM): incr = g;
            default:        incr = g & (r | s | lsb);
        endcase
    end

endmodule

// File: rtl/fp_normalize_round.sv
// FP add/sub back end: normalise, round, pack and raise fflags.
// Four-state FSM with a start/done handshake.
module fp_normalize_round
    import fp_pkg::*;
#(
    parameter  int Size     = 32,
    localparam int ExpSize  = exp_size(Size),
    localparam int MantSize = mant_size(Size),
    localparam int LzW      = $clog2(MantSize + 4)
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            rm,
    input  logic                  sign_in,
    input  logic                  carry_in,
    input  logic [ExpSize-1:0]    exp_in,
    input  logic [MantSize+3:0]   mant_in,
    input  logic [LzW-1:0]        leading_zeros,
    output logic                  busy,
    output logic                  done,
    output logic [Size-1:0]       result,
    output logic [4:0]            flags
);

    localparam int MW = MantSize + 4;
    localparam int EW = ExpSize + 1;
    localparam logic [EW-1:0] EXP_OVF = EW'((1 << ExpSize) - 1);

    state_t                state;
    logic                  sign_q;
    logic [2:0]            rm_q;
    logic [EW-1:0]         exp_q;
    logic [MW-1:0]         mant_q;
    logic [LzW-1:0]        lz_q;
    logic                  zero_q;
    logic                  inexact_q;
    logic [MantSize-1:0]   frac_q;

    logic [EW-1:0]         lz_ext;
    logic [EW-1:0]         shamt;
    logic [EW-1:0]         exp_norm;
    logic [MW-1:0]         mant_sh;

    logic                  incr;
    logic                  inexact;
    logic [MantSize+1:0]   sum;
    logic [EW-1:0]         exp_rnd;
    logic [MantSize-1:0]   frac_rnd;

    logic                  ovf;
    logic                  to_inf;
    logic [Size-1:0]       res_pack;
    logic [4:0]            flg_pack;

    // Normalising shift; subnormals stop shifting once exp reaches 1.
    always_comb begin
        lz_ext   = EW'(lz_q);
        shamt    = '0;
        exp_norm = '0;
        if (exp_q > lz_ext) begin
            shamt    = lz_ext;
            exp_norm = exp_q - lz_ext;
        end else if (exp_q != '0) begin
            shamt = exp_q - EW'(1);
        end
        mant_sh = (mant_q << shamt) | {{(MW-1){1'b0}}, mant_q[0]};
    end

    fp_round_incr u_round_incr (
        .rm      (rm_q),
        .sign    (sign_q),
        .lsb     (mant_q[3]),
        .g       (mant_q[2]),
        .r       (mant_q[1]),
        .s       (mant_q[0]),
        .incr    (incr),
        .inexact (inexact)
    );

    // Apply the increment and fix up the exponent on carry-out.
    always_comb begin
        sum      = {1'b0, mant_q[MW-1:3]} + (MantSize+2)'(incr);
        exp_rnd  = exp_q;
        frac_rnd = sum[MantSize-1:0];
        if (sum[MantSize+1]) begin
            exp_rnd  = exp_q + EW'(1);
            frac_rnd = sum[MantSize:1];
        end else if ((exp_q == '0) && sum[MantSize]) begin
            exp_rnd = EW'(1);
        end
    end

    // Assemble the packed result and flags, including overflow.
    always_comb begin
        ovf    = (exp_q >= EXP_OVF);
        to_inf = (rm_q == RM_RNE) |
                 (rm_q == RM_RMM) |
                 ((rm_q == RM_RUP) & ~sign_q) |
                 ((rm_q == RM_RDN) & sign_q);
        res_pack = '0;
        flg_pack = '0;
        if (zero_q) begin
            res_pack[Size-1] = (rm_q == RM_RDN);
        end else if (ovf) begin
            if (to_inf) begin
                res_pack = {sign_q, {ExpSize{1'b1}}, {MantSize{1'b0}}};
            end else begin
                res_pack = {sign_q, {(ExpSize-1){1'b1}}, 1'b0,
                            {MantSize{1'b1}}};
            end
            flg_pack[FLAG_OF] = 1'b1;
            flg_pack[FLAG_NX] = 1'b1;
        end else begin
            res_pack = {sign_q, exp_q[ExpSize-1:0], frac_q};
            flg_pack[FLAG_NX] = inexact_q;
            flg_pack[FLAG_UF] = inexact_q & (exp_q[ExpSize-1:0] == '0);
        end
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign_q    <= 1'b0;
            rm_q      <= '0;
            exp_q     <= '0;
            mant_q    <= '0;
            lz_q      <= '0;
            zero_q    <= 1'b0;
            inexact_q <= 1'b0;
            frac_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q    <= sign_in;
                        rm_q      <= rm_norm(rm);
                        exp_q     <= EW'(exp_in) + EW'(carry_in);
                        mant_q    <= mant_in;
                        lz_q      <= leading_zeros;
                        zero_q    <= 1'b0;
                        inexact_q <= 1'b0;
                        busy      <= 1'b1;
                        state     <= NORM;
                    end
                end
                NORM: begin
                    if (mant_q == '0) begin
                        zero_q <= 1'b1;
                        state  <= PACK;
                    end else begin
                        mant_q <= mant_sh;
                        exp_q  <= exp_norm;
                        state  <= ROUND;
                    end
                end
                ROUND: begin
                    exp_q     <= exp_rnd;
                    frac_q    <= frac_rnd;
                    inexact_q <= inexact;
                    state     <= PACK;
                end
                PACK: begin
                    result <= res_pack;
                    flags  <= flg_pack;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round (Size=32).
// Integer reference model; monitor pops expectations on done.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  rm = '0;
    logic        sign_in = 1'b0;
    logic        carry_in = 1'b0;
    logic [7:0]  exp_in = '0;
    logic [26:0] mant_in = '0;
    logic [4:0]  leading_zeros = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  flags;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass = 0;
    int n_done = 0;
    int n_issued = 0;

    always #5 clk = ~clk;

    fp_normalize_round #(.Size(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rm            (rm),
        .sign_in       (sign_in),
        .carry_in      (carry_in),
        .exp_in        (exp_in),
        .mant_in       (mant_in),
        .leading_zeros (leading_zeros),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .flags         (flags)
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Reference: value-level normalise and round with integer arithmetic.
    function automatic exp_t model(input logic s, input logic [2:0] r,
                                   input logic c, input logic [7:0] ex,
                                   input logic [26:0] m,
                                   input logic [4:0] lz);
        exp_t o;
        int ee, k, e, rmx;
        longint mm, keep, rem;
        bit up, inx, inf;
        rmx = (r > 3'd4) ? 0 : int'(r);
        ee = int'(ex) + int'(c);
        o = '0;
        if (m == 0) begin
            o.res = (rmx == 2) ? 32'h8000_0000 : 32'h0;
            return o;
        end
        if (ee > int'(lz)) begin
            k = int'(lz);
            e = ee - int'(lz);
        end else begin
            k = (ee > 0) ? ee - 1 : 0;
            e = 0;
        end
        mm = (longint'(m) * (64'sd1 << k)) % 134217728;
        if (k > 0) mm = mm + longint'(m) % 2;
        keep = mm / 8;
        rem = mm % 8;
        case (rmx)
            0: up = (rem > 4) || (rem == 4 && keep % 2 == 1);
            1: up = 0;
            2: up = (rem != 0) && s;
            3: up = (rem != 0) && !s;
            default: up = (rem >= 4);
        endcase
        keep = keep + longint'(up);
        if (keep >= 64'sd16777216) begin
            keep = keep / 2;
            e = e + 1;
        end else if (e == 0 && keep >= 64'sd8388608) begin
            e = 1;
        end
        inx = (rem != 0);
        if (e >= 255) begin
            inf = (rmx == 0) || (rmx == 4) || (rmx == 3 && !s) ||
                  (rmx == 2 && s);
            o.res = {s, inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
            o.flg = 5'b00101;
        end else begin
            o.res = {s, 8'(e), 23'(keep % 64'sd8388608)};
            o.flg = {3'b000, inx && e == 0, inx};
        end
        return o;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            n_done++;
            check("done_has_expectation", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("result", result, e.res);
                check("flags", flags, e.flg);
            end
        end
    end

    task automatic issue(input logic s, input logic [2:0] r,
                         input logic c, input logic [7:0] ex,
                         input logic [26:0] m, input logic [4:0] lz);
        @(negedge clk);
        sign_in = s;
        rm = r;
        carry_in = c;
        exp_in = ex;
        mant_in = m;
        leading_zeros = lz;
        start = 1'b1;
        q.push_back(model(s, r, c, ex, m, lz));
        n_issued++;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (busy && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [26:0] m;
        int lz;
        int top;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 + 1.0 with latency and busy profile
        issue(1'b0, 3'd0, 1'b1, 8'h7F, 27'h4000000, 5'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy_e%0d", i), 64'(busy), 64'd1);
            check($sformatf("done_e%0d", i), 64'(done), 64'd0);
            @(posedge clk);
            #1;
        end
        check("done_e3", 64'(done), 64'd1);
        check("busy_e3", 64'(busy), 64'd0);
        wait_idle();

        // Directed cases
        issue(1'b0, 3'd0, 1'b0, 8'h7F, 27'h0000008, 5'd23);
        wait_idle();
        issue(1'b0, 3'd0, 1'b0, 8'h7F, 27'h0, 5'd0);
        wait_idle();
        issue(1'b0, 3'd2, 1'b0, 8'h7F, 27'h0, 5'd0);
        wait_idle();
        issue(1'b0, 3'd0, 1'b0, 8'h7F, 27'h7FFFFFC, 5'd0);
        wait_idle();
        issue(1'b0, 3'd1, 1'b0, 8'h7F, 27'h7FFFFFC, 5'd0);
        wait_idle();
        issue(1'b0, 3'd4, 1'b0, 8'h7F, 27'h7FFFFFC, 5'd0);
        wait_idle();
        issue(1'b0, 3'd0, 1'b1, 8'hFE, 27'h4000000, 5'd0);
        wait_idle();
        issue(1'b0, 3'd1, 1'b1, 8'hFE, 27'h4000000, 5'd0);
        wait_idle();
        issue(1'b1, 3'd3, 1'b1, 8'hFE, 27'h4000000, 5'd0);
        wait_idle();
        issue(1'b0, 3'd0, 1'b0, 8'h01, 27'h0800001, 5'd3);
        wait_idle();
        issue(1'b1, 3'd6, 1'b0, 8'h7F, 27'h7FFFFFC, 5'd0);
        wait_idle();

        // Spot-check directed expectations against fixed constants
        check("model_1p1", 64'(model(0, 0, 1, 8'h7F, 27'h4000000, 0).res),
              64'h40000000);
        check("model_sub", 64'(model(0, 0, 0, 8'h01, 27'h0800001, 3)),
              {27'h0, 32'h00100000, 5'h03});

        // Randomised traffic, back to back
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                m = '0;
                lz = 0;
            end else begin
                lz = $urandom_range(0, 26);
                top = 26 - lz;
                m = (27'd1 << top) |
                    (27'($urandom()) & ((27'd1 << top) - 27'd1));
            end
            issue(1'($urandom()), 3'($urandom()), 1'($urandom()),
                  8'($urandom()), m, 5'(lz));
            wait_idle();
        end

        // start while busy is ignored
        issue(1'b0, 3'd0, 1'b1, 8'h7F, 27'h4000000, 5'd0);
        @(negedge clk);
        start = 1'b1;
        exp_in = 8'h10;
        mant_in = 27'h1234567;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check("ignore_start_dones", 64'(n_done), 64'(n_issued));

        // Reset during NORM aborts the operation
        issue(1'b0, 3'd0, 1'b0, 8'h7F, 27'h0000008, 5'd23);
        void'(q.pop_back());
        n_issued--;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 64'(n_done), 64'(n_issued));

        // Recovery after abort
        issue(1'b1, 3'd0, 1'b0, 8'h7F, 27'h7FFFFFC, 5'd0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("all_done", 64'(n_done), 64'(n_issued));
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
Back end of the FP adder/subtractor. Consumes the pre-normalised mantissa, leading-zero count and result sign from the OPERATION stage. Performs normalisation, subnormal handling, IEEE-754 rounding and packing, and raises the RISC-V fflags. Multi-cycle FSM with a start/done handshake; serves single (Size=32) and double (Size=64) precision.

Parameters:
Size, 32, operand width; 32 or 64.
ExpSize (localparam), 8 if Size==32 else 11, exponent field width.
MantSize (localparam), 23 if Size==32 else 52, fraction field width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
rm  in  3  RISC-V rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
sign_in  in  1  result sign from OPERATION stage.
carry_in  in  1  add carry-out; adds 1 to the exponent.
exp_in  in  ExpSize  biased exponent of the larger operand.
mant_in  in  MantSize+4  bit MantSize+3 = integer bit, then fraction, then G, R, S (bits 2..0).
leading_zeros  in  $clog2(MantSize+4)  leading zeros of mant_in.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse; result and flags are valid.
result  out  Size  packed IEEE result; held until the next done.
flags  out  5  {NV,DZ,OF,UF,NX}; NV and DZ are tied to 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, flags=0. All internal registers are cleared. A reset mid-operation aborts the operation with no done.
- States: IDLE -> NORM -> ROUND -> PACK -> IDLE.
  - IDLE: when start=1, latch all inputs and go to NORM.
  - Each other state lasts exactly 1 cycle.
  - done pulses in the cycle after PACK, together with the return to IDLE and the updated result/flags.
  - Latency: start sampled at edge 0 -> done=1 after edge 3.
- start while busy=1 is ignored; there is no queueing.
- Unsupported rm values (101, 110, 111) are treated as RNE. Illegal-rm trapping is the decoder's job.
- NORM:
  - exp_eff = exp_in + carry_in, ExpSize+1 bits wide.
  - mant_in==0: exact zero; result = {(rm==RDN), all zeros}; flags=0; skip to PACK. Signed-zero operands are resolved by the special-case path upstream.
  - exp_eff > leading_zeros: shift left by leading_zeros; exp = exp_eff - leading_zeros.
  - Otherwise (subnormal): shift left by exp_eff-1, saturating at 0; exp = 0.
  - Sticky (bit 0) is preserved through left shifts; zeros are shifted in.
- ROUND:
  - lsb = bit 3; inexact = G|R|S.
  - increment:
    - RNE: G & (R|S|lsb).
    - RTZ: 0.
    - RDN: inexact & sign.
    - RUP: inexact & ~sign.
    - RMM: G.
  - Rounded significand is MantSize+2 bits. On carry-out: shift right 1, exp+1.
  - Subnormal rounding up into bit MantSize: exp becomes 1.
- PACK:
  - Normal case: result = {sign, exp[ExpSize-1:0], frac}.
  - exp >= 2^ExpSize-1: overflow.
    - RNE, RMM, RUP with sign=0, and RDN with sign=1: result = ±inf.
    - Other combinations: result = max finite (exp = all-ones-1, frac = all ones).
    - OF=1, NX=1.
  - Flags: NX = inexact | OF. UF = inexact & (final exp field == 0); tininess is detected after rounding.

Decomposition:
- Package fp_pkg holds:
  - ExpSize/MantSize functions of Size.
  - Rounding-mode constants RM_RNE..RM_RMM.
  - Flag bit indices FLAG_NV..FLAG_NX.
  - State enum IDLE/NORM/ROUND/PACK.
- One sub-module, fp_round_incr: combinational. Inputs: rm, sign, lsb, G, R, S. Outputs: increment, inexact. It is reusable by the future multiplier.

Test Plan:
All cases use Size=32.
- 1.0+1.0: exp_in=0x7F, carry_in=1, mant_in=27'h4000000, lz=0, RNE -> result=0x40000000, flags=0; done exactly 3 cycles after start; busy high for 3 cycles.
- Cancellation: exp_in=0x7F, carry_in=0, mant_in=27'h0000008, lz=23 -> result=0x34000000, flags=0.
- Zero: mant_in=0 -> RNE gives 0x00000000, RDN gives 0x80000000, flags=0.
- Tie rounding: exp_in=0x7F, mant_in=27'h7FFFFFC, lz=0:
  - RNE -> 0x40000000, flags=0x01.
  - RTZ -> 0x3FFFFFFF, flags=0x01.
  - RMM -> 0x40000000.
- Overflow: exp_in=0xFE, carry_in=1, mant_in=27'h4000000, sign=0:
  - RNE -> 0x7F800000, flags=0x05.
  - RTZ -> 0x7F7FFFFF, flags=0x05.
  - sign=1, RUP -> 0xFF7FFFFF.
- Subnormal and control:
  - exp_in=0x01, mant_in=27'h0800001, lz=3, RNE -> result=0x00100000, flags=0x03.
  - start pulsed while busy -> ignored.
  - rst_n low during NORM -> busy=0, done=0, result=0 immediately, with no done afterwards.
